// File: rtl/decode_stage.sv
`default_nettype none
// =============================================================================
// decode_stage: registered decode with a destination-register scoreboard that
// stalls on RAW/WAW hazards. Option macro: DECODE_RETIRE_BYPASS_EN. Rev 1.0
// =============================================================================
module decode_stage #(
    parameter  int OPC_W   = 4,
    parameter  int REG_AW  = 3,
    parameter  int DATA_W  = 8,
    parameter  int CNT_W   = 16,
    localparam int INSTR_W = OPC_W + 3*REG_AW
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic               flush,
    input  logic               ret_valid,
    input  logic [REG_AW-1:0]  ret_rd,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_wb,
    output logic               out_const,
    output logic [OPC_W-2:0]   out_alu_op,
    output logic [REG_AW-1:0]  out_rd,
    output logic [REG_AW-1:0]  out_rs,
    output logic [REG_AW-1:0]  out_rt,
    output logic [DATA_W-1:0]  out_imm,
    output logic [CNT_W-1:0]   stall_cnt
);

    localparam int NREG  = 1 << REG_AW;
    localparam int ALU_W = OPC_W - 1;

    logic [OPC_W-1:0]  w_opc;
    logic [REG_AW-1:0] w_rd;
    logic [REG_AW-1:0] w_rs;
    logic [REG_AW-1:0] w_rt;
    logic              w_wb;
    logic              w_const;
    logic              w_hazard;
    logic              w_accept;
    logic [NREG-1:0]   w_ret_mask;
    logic [NREG-1:0]   w_set_mask;
    logic [NREG-1:0]   w_pend_lookup;

    logic [NREG-1:0]   r_pending;
    logic              r_out_valid;
    logic              r_wb;
    logic              r_const;
    logic [ALU_W-1:0]  r_alu_op;
    logic [REG_AW-1:0] r_rd;
    logic [REG_AW-1:0] r_rs;
    logic [REG_AW-1:0] r_rt;
    logic [DATA_W-1:0] r_imm;
    logic [CNT_W-1:0]  r_stall_cnt;

    assign w_opc   = in_instr[INSTR_W-1 -: OPC_W];
    assign w_rd    = in_instr[3*REG_AW-1 -: REG_AW];
    assign w_rs    = in_instr[2*REG_AW-1 -: REG_AW];
    assign w_rt    = in_instr[REG_AW-1:0];
    assign w_wb    = (w_opc != '0);
    assign w_const = w_opc[0];

    // Register 0 is hard-wired: neither mask ever touches bit 0.
    always_comb begin
        w_ret_mask = '0;
        for (int i = 1; i < NREG; i++) begin
            w_ret_mask[i] = ret_valid && (ret_rd == REG_AW'(i));
        end
    end

    always_comb begin
        w_set_mask = '0;
        for (int i = 1; i < NREG; i++) begin
            w_set_mask[i] = w_accept && w_wb && (w_rd == REG_AW'(i));
        end
    end

`ifdef DECODE_RETIRE_BYPASS_EN
    assign w_pend_lookup = r_pending & ~w_ret_mask;
`else
    assign w_pend_lookup = r_pending;
`endif

    assign w_hazard = w_pend_lookup[w_rs]
                    | (!w_const && w_pend_lookup[w_rt])
                    | (w_wb && w_pend_lookup[w_rd]);

    assign in_ready = (!r_out_valid || out_ready) && !w_hazard && !flush;
    assign w_accept = in_valid && in_ready;

    // Set is OR-ed after the clear so a same-cycle set on one register wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending <= '0;
        end else if (flush) begin
            r_pending <= '0;
        end else begin
            r_pending <= (r_pending & ~w_ret_mask) | w_set_mask;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_wb        <= 1'b0;
            r_const     <= 1'b0;
            r_alu_op    <= '0;
            r_rd        <= '0;
            r_rs        <= '0;
            r_rt        <= '0;
            r_imm       <= '0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_wb        <= w_wb;
            r_const     <= w_const;
            r_alu_op    <= w_opc[OPC_W-1:1];
            r_rd        <= w_rd;
            r_rs        <= w_rs;
            r_rt        <= w_rt;
            r_imm       <= DATA_W'(w_rt);
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (in_valid && w_hazard && !flush && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign out_valid  = r_out_valid;
    assign out_wb     = r_wb;
    assign out_const  = r_const;
    assign out_alu_op = r_alu_op;
    assign out_rd     = r_rd;
    assign out_rs     = r_rs;
    assign out_rt     = r_rt;
    assign out_imm    = r_imm;
    assign stall_cnt  = r_stall_cnt;

endmodule
`default_nettype wire

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered, parametrised instruction decode stage between fetch and the ALU/register-file stage.
- Splits an instruction word into opcode, rd, rs and rt/immediate fields.
- Generates control signals: writeback enable, constant select, ALU op.
- Tracks in-flight destination registers in a scoreboard and stalls the upstream valid/ready handshake on RAW/WAW hazards until retire.

Parameters:
- OPC_W, 4, opcode width; alu_op width is OPC_W-1.
- REG_AW, 3, register address width; register count is 2^REG_AW; instruction width INSTR_W = OPC_W + 3*REG_AW.
- DATA_W, 8, immediate output width; rt field zero-extended into it; must be >= REG_AW.
- CNT_W, 16, width of the hazard stall counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  upstream instruction valid.
- in_ready  out  1  stage accepts instruction this cycle.
- in_instr  in  INSTR_W  instruction {opcode, rd, rs, rt}, opcode at MSBs.
- flush  in  1  synchronous squash of stage and scoreboard.
- ret_valid  in  1  a writer retires this cycle.
- ret_rd  in  REG_AW  retiring destination register.
- out_valid  out  1  decoded instruction valid.
- out_ready  in  1  downstream accepts.
- out_wb  out  1  writeback enable.
- out_const  out  1  immediate select.
- out_alu_op  out  OPC_W-1  ALU operation.
- out_rd, out_rs, out_rt  out  REG_AW each  register addresses.
- out_imm  out  DATA_W  rt zero-extended.
- stall_cnt  out  CNT_W  count of hazard-stalled cycles.

Behaviour:
- Reset (async, rst=1): all of the following are 0: out_valid, out_wb, out_const, out_alu_op, out_rd, out_rs, out_rt, out_imm, stall_cnt, and every scoreboard pending bit. in_ready is combinational and follows from that state.
- Decode rules:
  - wb = (opcode != 0).
  - const = opcode[0].
  - alu_op = opcode[OPC_W-1:1].
  - imm = {0, rt}.
- Hazard, combinational, on in_instr:
  - pending[rs].
  - OR (!const AND pending[rt]).
  - OR (wb AND pending[rd]).
  - Register 0 is never pending; a set request for rd=0 is ignored.
- in_ready = (!out_valid OR out_ready) AND !hazard AND !flush.
- Accept = in_valid AND in_ready. On accept:
  - Output registers load the decoded fields; out_valid=1 on the next edge. Latency is exactly 1 cycle.
  - If wb, set pending[rd].
- If out_valid AND out_ready with no accept: out_valid <= 0 and the data registers hold. Outputs are stable while out_valid AND !out_ready.
- Retire: ret_valid clears pending[ret_rd] at the next edge. If ret_rd=0, nothing changes.
  - Without the optional feature, a retire is not visible to the hazard check in the same cycle.
- Same-cycle set and clear of one register: set wins.
- flush: out_valid <= 0 and all pending bits <= 0. flush overrides accept and retire in the same cycle. stall_cnt is unaffected.
- stall_cnt increments when in_valid AND hazard AND !flush. It saturates at all-ones with no wrap.
- Reset asserted mid-stall or mid-handshake: everything returns to reset values immediately; no instruction is retained.

Optional Feature:
- Macro: DECODE_RETIRE_BYPASS_EN.
- Defined: hazard lookup uses pending & ~(ret_valid ? onehot(ret_rd) : 0). A register retiring this cycle does not stall, so an instruction dependent on it is accepted in the same cycle as the retire.
- Undefined: hazard uses the registered pending bits only; an extra stall cycle follows each retire.

Test Plan:
1. Reset, then in_instr=13'h068D (op 0011, rd2, rs1, imm5) with in_valid=1, out_ready=1 -> next cycle out_valid=1, out_wb=1, out_const=1, out_alu_op=3'b001, out_rd=2, out_imm=8'h05; pending[2]=1.
2. After test 1, present op 0100, rd3, rs2, rt1 -> in_ready=0 and stall_cnt increments every cycle. Pulse ret_valid with ret_rd=2:
   - Bypass undefined: in_ready rises the cycle after the retire.
   - Bypass defined: in_ready rises in the retire cycle itself.
3. Instruction with opcode 0000, rd5 -> out_wb=0 and pending[5] stays 0. Instruction writing rd0 -> never stalls a later reader of r0.
4. out_ready=0 with out_valid=1 -> in_ready=0 and outputs hold their values over 3 cycles. Release out_ready -> the held instruction transfers and a new one loads in the same cycle.
5. pending[2] and pending[3] set, then flush=1 together with in_valid=1 -> no accept, out_valid=0 next cycle, all pending bits clear, and the next reader of r2 is accepted without stall.
6. Force 2^CNT_W+5 stall cycles -> stall_cnt holds at all-ones. Assert rst mid-stall -> stall_cnt=0 and out_valid=0 asynchronously.
